// File: rtl/pca9685_register_file_pkg.sv
// Shared constants, reset values and FSM state type
// for the PCA9685 register store.
package pca9685_regs_pkg;

    localparam int MODE1        = 0;
    localparam int MODE2        = 1;
    localparam int LED_BASE     = 6;
    localparam int ALL_LED_BASE = 250;
    localparam int PRE_SCALE    = 254;

    localparam int AI      = 5;
    localparam int SLEEP   = 4;
    localparam int RESTART = 7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BCAST = 1'b1
    } bcast_state_e;

    function automatic logic [7:0] reset_value(input int addr, input int num_led);
        logic [7:0] v;
        v = 8'h00;
        case (addr)
            0:         v = 8'h11;
            1:         v = 8'h04;
            2:         v = 8'hE2;
            3:         v = 8'hE4;
            4:         v = 8'hE8;
            5:         v = 8'hE0;
            PRE_SCALE: v = 8'h1E;
            default: begin
                // LEDn_OFF_H powers up with the full-off bit set
                if (addr >= LED_BASE && addr < LED_BASE + 4 * num_led
                    && ((addr - LED_BASE) % 4) == 3)
                    v = 8'h10;
            end
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pca9685_register_file_if.sv
// Command / readback bundle between the I2C byte engine
// and the PCA9685 register store.
interface pca9685_register_file_if #(
    parameter int NUM_REGS = 256,
    parameter int DATA_W   = 8
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                         ptr_load_i;
    logic [ADDR_W-1:0]            ptr_value_i;
    logic                         wr_en_i;
    logic [DATA_W-1:0]            wr_data_i;
    logic                         rd_en_i;
    logic [DATA_W-1:0]            rd_data_o;
    logic                         rd_valid_o;
    logic                         ready_o;
    logic [ADDR_W-1:0]            ptr_o;
    logic [0:NUM_REGS*DATA_W-1]   register_blob_o;

    modport master (
        output ptr_load_i, ptr_value_i, wr_en_i, wr_data_i, rd_en_i,
        input  rd_data_o, rd_valid_o, ready_o, ptr_o, register_blob_o
    );

    modport slave (
        input  ptr_load_i, ptr_value_i, wr_en_i, wr_data_i, rd_en_i,
        output rd_data_o, rd_valid_o, ready_o, ptr_o, register_blob_o
    );

endinterface

// File: rtl/pca9685_register_file_reg_pointer.sv
// Control pointer: explicit load, or MODE1.AI auto-increment
// with wrap after LAST_AI_REG and at the top of the map.
module pca9685_reg_pointer #(
    parameter int NUM_REGS    = 256,
    parameter int LAST_AI_REG = 69,
    parameter int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_value,
    input  logic              i_step,
    input  logic              i_ai,
    output logic [ADDR_W-1:0] o_ptr
);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_next;
    logic [31:0]       w_p32;

    assign w_p32 = 32'(r_ptr);

    always_comb begin
        w_next = r_ptr;
        if (i_load) begin
            w_next = i_value;
        end else if (i_step && i_ai) begin
            if (w_p32 == LAST_AI_REG || w_p32 >= NUM_REGS - 1)
                w_next = '0;
            else
                w_next = r_ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            r_ptr <= '0;
        else
            r_ptr <= w_next;
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/pca9685_register_file.sv
// PCA9685 register store: pointer-addressed access, registered
// readback, PRE_SCALE guard and ALL_LED broadcast sequencer.
module pca9685_register_file
    import pca9685_regs_pkg::*;
#(
    parameter int NUM_REGS    = 256,
    parameter int DATA_W      = 8,
    parameter int NUM_LED     = 16,
    parameter int LAST_AI_REG = 69
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    pca9685_register_file_if.slave  bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int CNT_W  = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

    localparam logic [0:0] S_IDLE  = ST_IDLE;
    localparam logic [0:0] S_BCAST = ST_BCAST;

    logic [DATA_W-1:0]          r_regs [NUM_REGS];
    logic [0:0]                 r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [1:0]                 r_k;
    logic [DATA_W-1:0]          r_bc_data;
    logic [DATA_W-1:0]          r_rd_data;
    logic                       r_rd_valid;

    logic [ADDR_W-1:0]          w_ptr;
    logic [31:0]                w_p32;
    logic                       w_ready;
    logic                       w_acc_load;
    logic                       w_acc_wr;
    logic                       w_acc_rd;
    logic                       w_in_range;
    logic                       w_is_all;
    logic                       w_is_pre;
    logic [DATA_W-1:0]          w_mode1;
    logic                       w_start_bc;
    logic [1:0]                 w_k;
    logic [31:0]                w_bc_a32;
    logic                       w_we;
    logic [ADDR_W-1:0]          w_waddr;
    logic [DATA_W-1:0]          w_wdata;
    logic [DATA_W-1:0]          w_rdata;
    logic [0:NUM_REGS*DATA_W-1] w_blob;

    assign w_ready    = (r_state == S_IDLE);
    assign w_acc_load = w_ready && bus.ptr_load_i;
    assign w_acc_wr   = w_ready && !bus.ptr_load_i && bus.wr_en_i;
    assign w_acc_rd   = w_ready && !bus.ptr_load_i && !bus.wr_en_i
                        && bus.rd_en_i;

    assign w_p32      = 32'(w_ptr);
    assign w_in_range = (w_p32 < NUM_REGS);
    assign w_is_all   = (w_p32 >= ALL_LED_BASE) && (w_p32 <= ALL_LED_BASE + 3);
    assign w_is_pre   = (w_p32 == PRE_SCALE);
    assign w_mode1    = r_regs[MODE1];
    assign w_start_bc = w_acc_wr && w_is_all;
    assign w_k        = 2'(w_p32 - ALL_LED_BASE);
    assign w_bc_a32   = LED_BASE + 4 * 32'(r_cnt) + 32'(r_k);

    pca9685_reg_pointer #(
        .NUM_REGS    (NUM_REGS),
        .LAST_AI_REG (LAST_AI_REG),
        .ADDR_W      (ADDR_W)
    ) u_ptr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_load  (w_acc_load),
        .i_value (bus.ptr_value_i),
        .i_step  (w_acc_wr || w_acc_rd),
        .i_ai    (w_mode1[AI]),
        .o_ptr   (w_ptr)
    );

    // single write port shared by the sweep and host writes
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_ptr;
        w_wdata = bus.wr_data_i;
        if (r_state == S_BCAST) begin
            w_we    = 1'b1;
            w_waddr = ADDR_W'(w_bc_a32);
            w_wdata = r_bc_data;
        end else if (w_acc_wr && w_in_range && !w_is_all) begin
            w_we = !w_is_pre || w_mode1[SLEEP];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++)
                r_regs[r] <= DATA_W'(reset_value(r, NUM_LED));
        end else if (w_we) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_k       <= '0;
            r_bc_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_bc) begin
                        r_state   <= S_BCAST;
                        r_cnt     <= '0;
                        r_k       <= w_k;
                        r_bc_data <= bus.wr_data_i;
                    end
                end
                S_BCAST: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(NUM_LED - 1))
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_rdata = (w_in_range && !w_is_all) ? r_regs[w_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_acc_rd;
            if (w_acc_rd)
                r_rd_data <= w_rdata;
        end
    end

    always_comb begin
        w_blob = '0;
        for (int r = 0; r < NUM_REGS; r++)
            w_blob[r*DATA_W +: DATA_W] = r_regs[r];
    end

    assign bus.rd_data_o       = r_rd_data;
    assign bus.rd_valid_o      = r_rd_valid;
    assign bus.ready_o         = w_ready;
    assign bus.ptr_o           = w_ptr;
    assign bus.register_blob_o = w_blob;

endmodule

// File: tb/tb_pca9685_register_file.sv
// Directed self-checking bench for pca9685_register_file.
module tb_pca9685_register_file;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pca9685_register_file_if #(.NUM_REGS(256), .DATA_W(8)) bus ();

    pca9685_register_file #(
        .NUM_REGS(256), .DATA_W(8), .NUM_LED(16), .LAST_AI_REG(69)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    function automatic logic [7:0] rg(input int r);
        return bus.register_blob_o[r*8 +: 8];
    endfunction

    task automatic idle_bus();
        bus.ptr_load_i  = 1'b0;
        bus.ptr_value_i = 8'h00;
        bus.wr_en_i     = 1'b0;
        bus.wr_data_i   = 8'h00;
        bus.rd_en_i     = 1'b0;
    endtask

    task automatic cmd(input logic ld, input logic [7:0] pv,
                       input logic we, input logic [7:0] wd,
                       input logic re);
        @(negedge clk);
        bus.ptr_load_i  = ld;
        bus.ptr_value_i = pv;
        bus.wr_en_i     = we;
        bus.wr_data_i   = wd;
        bus.rd_en_i     = re;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic test_reset();
        idle_bus();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (rg(0) !== 8'h11) begin bad++; $display("FAIL reset_mode1 got %h want 11", rg(0)); end
        total++; if (rg(1) !== 8'h04) begin bad++; $display("FAIL reset_mode2 got %h want 04", rg(1)); end
        total++; if (rg(3) !== 8'hE4) begin bad++; $display("FAIL reset_subadr2 got %h want e4", rg(3)); end
        total++; if (rg(5) !== 8'hE0) begin bad++; $display("FAIL reset_allcall got %h want e0", rg(5)); end
        total++; if (rg(9) !== 8'h10) begin bad++; $display("FAIL reset_led0_offh got %h want 10", rg(9)); end
        total++; if (rg(69) !== 8'h10) begin bad++; $display("FAIL reset_led15_offh got %h want 10", rg(69)); end
        total++; if (rg(10) !== 8'h00) begin bad++; $display("FAIL reset_led1_onl got %h want 00", rg(10)); end
        total++; if (rg(254) !== 8'h1E) begin bad++; $display("FAIL reset_prescale got %h want 1e", rg(254)); end
        total++; if (bus.register_blob_o[9*8+3] !== 1'b1) begin bad++; $display("FAIL reset_blob_bit got %b want 1", bus.register_blob_o[9*8+3]); end
        total++; if (bus.ptr_o !== 8'd0) begin bad++; $display("FAIL reset_ptr got %0d want 0", bus.ptr_o); end
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
        total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid_o); end
        total++; if (bus.rd_data_o !== 8'h00) begin bad++; $display("FAIL reset_rd_data got %h want 00", bus.rd_data_o); end
    endtask

    task automatic test_ai_write();
        logic [7:0] exp_v [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        cmd(1, 8'd0, 0, 8'h00, 0);
        cmd(0, 8'd0, 1, 8'h21, 0);
        total++; if (rg(0) !== 8'h21) begin bad++; $display("FAIL ai_mode1 got %h want 21", rg(0)); end
        total++; if (bus.ptr_o !== 8'd0) begin bad++; $display("FAIL ai_old_mode1 ptr got %0d want 0", bus.ptr_o); end
        cmd(1, 8'd6, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) cmd(0, 8'd0, 1, exp_v[i], 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rg(6 + i) !== exp_v[i]) begin bad++; $display("FAIL ai_reg%0d got %h want %h", 6 + i, rg(6 + i), exp_v[i]); end
        end
        total++; if (bus.ptr_o !== 8'd10) begin bad++; $display("FAIL ai_ptr got %0d want 10", bus.ptr_o); end
        cmd(1, 8'd6, 0, 8'h00, 0);
        cmd(0, 8'd0, 0, 8'h00, 1);
        total++; if (bus.rd_valid_o !== 1'b1) begin bad++; $display("FAIL rd_valid got %b want 1", bus.rd_valid_o); end
        total++; if (bus.rd_data_o !== 8'h01) begin bad++; $display("FAIL rd_data got %h want 01", bus.rd_data_o); end
        total++; if (bus.ptr_o !== 8'd7) begin bad++; $display("FAIL rd_ptr_inc got %0d want 7", bus.ptr_o); end
        @(posedge clk); #1;
        total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL rd_valid_pulse got %b want 0", bus.rd_valid_o); end
        total++; if (bus.rd_data_o !== 8'h01) begin bad++; $display("FAIL rd_data_hold got %h want 01", bus.rd_data_o); end
    endtask

    task automatic test_wrap();
        cmd(1, 8'd69, 0, 8'h00, 0);
        cmd(0, 8'd0, 1, 8'hAA, 0);
        total++; if (rg(69) !== 8'hAA) begin bad++; $display("FAIL wrap_reg69 got %h want aa", rg(69)); end
        total++; if (bus.ptr_o !== 8'd0) begin bad++; $display("FAIL wrap69_ptr got %0d want 0", bus.ptr_o); end
        cmd(1, 8'd255, 0, 8'h00, 0);
        cmd(0, 8'd0, 0, 8'h00, 1);
        total++; if (bus.ptr_o !== 8'd0) begin bad++; $display("FAIL wrap255_ptr got %0d want 0", bus.ptr_o); end
        total++; if (bus.rd_data_o !== 8'h00) begin bad++; $display("FAIL rd255 got %h want 00", bus.rd_data_o); end
        cmd(0, 8'd0, 1, 8'h01, 0);
        total++; if (bus.ptr_o !== 8'd1) begin bad++; $display("FAIL ai_off_write ptr got %0d want 1", bus.ptr_o); end
        cmd(1, 8'd7, 0, 8'h00, 0);
        cmd(0, 8'd0, 1, 8'h33, 0);
        cmd(0, 8'd0, 1, 8'h44, 0);
        total++; if (bus.ptr_o !== 8'd7) begin bad++; $display("FAIL noai_ptr got %0d want 7", bus.ptr_o); end
        total++; if (rg(7) !== 8'h44) begin bad++; $display("FAIL noai_reg7 got %h want 44", rg(7)); end
    endtask

    task automatic test_bcast();
        int cnt;
        cmd(1, 8'd252, 0, 8'h00, 0);
        cmd(0, 8'd0, 1, 8'h55, 0);
        cnt = 0;
        while (bus.ready_o !== 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 2) begin bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h99; end
            if (cnt == 6) idle_bus();
            @(posedge clk); #1;
        end
        idle_bus();
        total++; if (cnt !== 16) begin bad++; $display("FAIL bcast_ready_low cycles got %0d want 16", cnt); end
        for (int n = 0; n < 16; n++) begin
            total++;
            if (rg(8 + 4 * n) !== 8'h55) begin bad++; $display("FAIL bcast_reg%0d got %h want 55", 8 + 4 * n, rg(8 + 4 * n)); end
        end
        total++; if (rg(6) !== 8'h01) begin bad++; $display("FAIL bcast_reg6 got %h want 01", rg(6)); end
        total++; if (rg(7) !== 8'h44) begin bad++; $display("FAIL bcast_reg7 got %h want 44", rg(7)); end
        total++; if (rg(9) !== 8'h04) begin bad++; $display("FAIL bcast_reg9 got %h want 04", rg(9)); end
        total++; if (rg(69) !== 8'hAA) begin bad++; $display("FAIL bcast_reg69 got %h want aa", rg(69)); end
        total++; if (rg(252) !== 8'h00) begin bad++; $display("FAIL bcast_reg252 got %h want 00", rg(252)); end
        total++; if (bus.ptr_o !== 8'd252) begin bad++; $display("FAIL bcast_ptr got %0d want 252", bus.ptr_o); end
        cmd(0, 8'd0, 0, 8'h00, 1);
        total++; if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== 8'h00) begin bad++; $display("FAIL rd252 got %b/%h want 1/00", bus.rd_valid_o, bus.rd_data_o); end
    endtask

    task automatic test_prescale();
        cmd(1, 8'd254, 0, 8'h00, 0);
        cmd(0, 8'd0, 1, 8'h79, 0);
        total++; if (rg(254) !== 8'h1E) begin bad++; $display("FAIL prescale_guard got %h want 1e", rg(254)); end
        cmd(1, 8'd0, 0, 8'h00, 0);
        cmd(0, 8'd0, 1, 8'h11, 0);
        cmd(1, 8'd254, 0, 8'h00, 0);
        cmd(0, 8'd0, 1, 8'h79, 0);
        total++; if (rg(254) !== 8'h79) begin bad++; $display("FAIL prescale_sleep got %h want 79", rg(254)); end
    endtask

    task automatic test_reset_mid_bcast();
        cmd(1, 8'd250, 0, 8'h00, 0);
        cmd(0, 8'd0, 1, 8'h77, 0);
        repeat (4) begin @(posedge clk); #1; end
        total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL midsweep_ready got %b want 0", bus.ready_o); end
        total++; if (rg(6) !== 8'h77) begin bad++; $display("FAIL midsweep_reg6 got %h want 77", rg(6)); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (rg(6) !== 8'h00) begin bad++; $display("FAIL rstabort_reg6 got %h want 00", rg(6)); end
        total++; if (rg(9) !== 8'h10) begin bad++; $display("FAIL rstabort_reg9 got %h want 10", rg(9)); end
        total++; if (rg(0) !== 8'h11) begin bad++; $display("FAIL rstabort_mode1 got %h want 11", rg(0)); end
        total++; if (rg(254) !== 8'h1E) begin bad++; $display("FAIL rstabort_prescale got %h want 1e", rg(254)); end
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL rstabort_ready got %b want 1", bus.ready_o); end
        total++; if (bus.ptr_o !== 8'd0) begin bad++; $display("FAIL rstabort_ptr got %0d want 0", bus.ptr_o); end
        repeat (20) @(posedge clk);
        #1;
        total++; if (rg(62) !== 8'h00 || rg(66) !== 8'h00) begin bad++; $display("FAIL rstabort_late got %h/%h want 00/00", rg(62), rg(66)); end
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL rstabort_ready_late got %b want 1", bus.ready_o); end
    endtask

    task automatic test_priority();
        cmd(1, 8'd20, 1, 8'h5A, 1);
        total++; if (bus.ptr_o !== 8'd20) begin bad++; $display("FAIL prio_load_ptr got %0d want 20", bus.ptr_o); end
        total++; if (rg(20) !== 8'h00 || rg(0) !== 8'h11) begin bad++; $display("FAIL prio_load_nowrite got %h/%h want 00/11", rg(20), rg(0)); end
        total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL prio_load_noread got %b want 0", bus.rd_valid_o); end
        cmd(0, 8'd0, 1, 8'h3C, 1);
        total++; if (rg(20) !== 8'h3C) begin bad++; $display("FAIL prio_wr got %h want 3c", rg(20)); end
        total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("FAIL prio_wr_noread got %b want 0", bus.rd_valid_o); end
        cmd(0, 8'd0, 0, 8'h00, 1);
        total++; if (bus.rd_data_o !== 8'h3C) begin bad++; $display("FAIL prio_readback got %h want 3c", bus.rd_data_o); end
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_ai_write();
        test_wrap();
        test_bcast();
        test_prescale();
        test_reset_mid_bcast();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

endmodule

// File: doc/pca9685_register_file.md
Name: pca9685_register_file

Overview:
Next-generation PCA9685 register store, parametrised in register count, data width and LED channel count. Sits behind the I2C slave byte engine and feeds the PWM generators via the flat register blob. Compared with the plain write-only store, it adds:
- a control pointer with MODE1.AI auto-increment and wrap-around;
- a registered read port;
- datasheet reset values;
- the PRE_SCALE write guard;
- ALL_LED broadcast writes, executed by a multi-cycle sequencer with a ready handshake.

Parameters:
NUM_REGS, 256, number of 8-bit registers; ADDR_W = clog2(NUM_REGS).
DATA_W, 8, register width in bits.
NUM_LED, 16, number of LEDn register groups, 4 bytes each, starting at address 6.
LAST_AI_REG, 69, address after which auto-increment wraps to 0 (LED15_OFF_H).

Ports:
clk_i  in  1  clock; every register updates on its rising edge.
rst_ni  in  1  reset; synchronous and active-low.
ptr_load_i  in  1  load the control pointer from ptr_value_i.
ptr_value_i  in  ADDR_W  new pointer value.
wr_en_i  in  1  write wr_data_i to the register addressed by the pointer.
wr_data_i  in  DATA_W  write data.
rd_en_i  in  1  read the register addressed by the pointer.
rd_data_o  out  DATA_W  read data, registered.
rd_valid_o  out  1  one-cycle pulse qualifying rd_data_o.
ready_o  out  1  high when a command can be accepted.
ptr_o  out  ADDR_W  current control pointer.
register_blob_o  out  NUM_REGS*DATA_W  packed as [0:N-1]. Register r occupies bits r*8..r*8+7, MSB of the byte first.

Behaviour:
- Reset (rst_ni low at a clock edge) applies regardless of state. It aborts any broadcast in progress. After reset:
  - ptr_o=0, rd_valid_o=0, rd_data_o=0, ready_o=1, FSM=IDLE.
  - Register values: MODE1(0)=0x11, MODE2(1)=0x04, SUBADR1-3(2-4)=0xE2/0xE4/0xE8, ALLCALLADR(5)=0xE0.
  - Every LEDn_OFF_H (6+4n+3) = 0x10.
  - PRE_SCALE(254)=0x1E.
  - All other registers 0.
- Command acceptance:
  - A command is accepted only in a cycle with ready_o=1; upstream holds the command while ready_o=0.
  - Commands presented while ready_o=0 have no effect.
  - At most one command is accepted per cycle, with priority ptr_load_i > wr_en_i > rd_en_i. Lower-priority commands in the same cycle are dropped.
- Pointer load: ptr_o = ptr_value_i on the next cycle.
- Auto-increment: applies after every accepted read or write.
  - If MODE1[5]=0 (AI off), the pointer is unchanged.
  - If MODE1[5]=1: ptr==LAST_AI_REG -> 0; otherwise ptr+1 modulo NUM_REGS (so 255 -> 0).
  - The MODE1 value in effect is the value before the write.
- Write: the register is updated at the edge that accepts the write. Exceptions:
  - 250-253 (ALL_LED_*): trigger a broadcast; the registers themselves stay 0.
  - 254 (PRE_SCALE): the write is ignored unless MODE1[4]=1 (SLEEP). The pointer still increments.
  - Addresses >= NUM_REGS: the write is ignored.
- Read:
  - rd_data_o = register[ptr] on the cycle after acceptance, with rd_valid_o=1 for exactly that cycle.
  - Addresses 250-253 read 0x00.
  - rd_data_o holds its value between reads.
- Broadcast FSM, states IDLE and BCAST:
  - IDLE -> BCAST on an accepted write to 250+k (k=0..3). The FSM latches k and the data; counter n=0.
  - In BCAST, ready_o=0. Each cycle the FSM writes register 6+4n+k and increments n.
  - After the n=NUM_LED-1 write, the FSM returns to IDLE.
  - ready_o is low for exactly NUM_LED cycles after acceptance, then high.
  - The pointer increments at acceptance, not during the sweep.
- MODE1 bit 7 (RESTART) is stored as written; it has no side effects here.

Decomposition:
- Package pca9685_regs_pkg holds:
  - address constants: MODE1=0, MODE2=1, LED_BASE=6, ALL_LED_BASE=250, PRE_SCALE=254;
  - bit indices: AI=5, SLEEP=4, RESTART=7;
  - a reset_value(addr) function;
  - the FSM state enum.
- One sub-module is natural: pca9685_reg_pointer. It contains the pointer register, load logic and the AI increment/wrap rule.

Test Plan:
1. Reset -> MODE1=0x11, MODE2=0x04, reg 9 (LED0_OFF_H)=0x10, reg 254=0x1E, ptr_o=0, ready_o=1.
2. Write MODE1=0x21, load ptr 6, write 0x01,0x02,0x03,0x04 -> regs 6..9 = 01..04, ptr_o=10. Read at ptr 6 -> rd_data_o=0x01 with rd_valid_o one cycle later.
3. With AI=1, load ptr 69, write 0xAA -> reg 69=0xAA, ptr_o=0. With AI=0, two writes at ptr 7 -> ptr_o stays 7, reg 7 holds the second value.
4. Write 0x55 at 252 -> ready_o low exactly 16 cycles; afterwards regs 8,12,...,68 = 0x55 and reg 252 reads 0x00. A wr_en_i asserted during the sweep changes nothing.
5. With MODE1=0x01, write 0x79 to 254 -> stays 0x1E. Set MODE1=0x11, write 0x79 to 254 -> 0x79.
6. Assert rst_ni=0 on sweep cycle 5 -> all reset values restored, FSM=IDLE, ready_o=1, no further LED writes.
